// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: two-stage pipelined unsigned approximate multiplier with a
// valid/ready stream interface, per-transaction exact/approximate mode and a
// saturating statistics unit (delivered-result count and accumulated error).
//
// In approximate mode the x-rows i >= L are computed exactly, while the low
// x-rows i < L drop every partial product whose column i+j is below K. The
// dropped amount is reported on err, so z + err is always the exact product.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   in_valid  in   1      operands valid
//   in_ready  out  1      operands accepted this cycle
//   x, y      in   N      multiplier / multiplicand
//   approx    in   1      1 = approximate, 0 = exact (captured per operand pair)
//   out_valid out  1      result valid
//   out_ready in   1      consumer accepts result
//   z         out  2N     product
//   err       out  2N     exact product minus z
//   stat_clr  in   1      synchronous clear of the statistics counters
//   txn_cnt   out  ACC_W  delivered results (saturating)
//   err_acc   out  ACC_W  sum of delivered err (saturating)
module approx_mul_pipe #(
  parameter int N     = 8,
  parameter int L     = 4,
  parameter int K     = N,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic             approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   z,
  output logic [2*N-1:0]   err,
  input  logic             stat_clr,
  output logic [ACC_W-1:0] txn_cnt,
  output logic [ACC_W-1:0] err_acc
);

  localparam int W2 = 2 * N;

  // Partial-product split of the incoming operands.
  logic [W2-1:0] h_part;   // exact high rows
  logic [W2-1:0] kl_part;  // low-row products that are kept
  logic [W2-1:0] dl_part;  // low-row products that approximation drops

  // NOTE: every variable driven here gets a default first, otherwise an
  // unassigned path would infer a latch.
  always_comb begin
    h_part  = '0;
    kl_part = '0;
    dl_part = '0;
    for (int i = 0; i < N; i++) begin
      if (i >= L) begin
        if (x[i]) h_part = h_part + (W2'(y) << i);
      end else begin
        for (int j = 0; j < N; j++) begin
          if (x[i] && y[j]) begin
            if (i + j >= K) kl_part = kl_part + (W2'(1) << (i + j));
            else            dl_part = dl_part + (W2'(1) << (i + j));
          end
        end
      end
    end
  end

  // Pipeline control.
  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  // Same condition as s1_load, written in its interface form; it depends on
  // out_ready but never on in_valid.
  assign in_ready  = !(s1_valid && s2_valid && !out_ready);
  assign out_valid = s2_valid;

  // Stage 1 payload.
  logic [W2-1:0] s1_h;
  logic [W2-1:0] s1_kl;
  logic [W2-1:0] s1_dl;
  logic          s1_approx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s2_load) s2_valid <= s1_valid;
    end
  end

  // NOTE: stage-1 payload is qualified by s1_valid, so it carries no reset;
  // only the valid bits and the visible outputs need a defined reset value.
  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_h      <= h_part;
      s1_kl     <= kl_part;
      s1_dl     <= dl_part;
      s1_approx <= approx;
    end
  end

  // Stage 2: final sum and error; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z   <= '0;
      err <= '0;
    end else if (s2_load && s1_valid) begin
      z   <= s1_h + s1_kl + (s1_approx ? '0 : s1_dl);
      err <= s1_approx ? s1_dl : '0;
    end
  end

  // Statistics: saturating counters updated on each output handshake.
  logic             out_hs;
  logic [ACC_W:0]   txn_sum;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] err_ext;

  assign out_hs  = s2_valid && out_ready;
  assign err_ext = ACC_W'(err);
  assign txn_sum = {1'b0, txn_cnt} + {{ACC_W{1'b0}}, 1'b1};
  assign acc_sum = {1'b0, err_acc} + {1'b0, err_ext};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt <= '0;
      err_acc <= '0;
    end else if (stat_clr) begin
      // A handshake in the clear cycle becomes the first counted result.
      txn_cnt <= out_hs ? {{(ACC_W-1){1'b0}}, 1'b1} : '0;
      err_acc <= out_hs ? err_ext : '0;
    end else if (out_hs) begin
      txn_cnt <= txn_sum[ACC_W] ? '1 : txn_sum[ACC_W-1:0];
      err_acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb_approx_mul_pipe: directed self-checking bench for approx_mul_pipe
// (N=8, L=4, K=8, ACC_W=16). Each scenario task drives stimulus and compares
// against hand-computed expectations.
module tb_approx_mul_pipe;

  localparam int N     = 8;
  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     x;
  logic [N-1:0]     y;
  logic             approx;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   z;
  logic [2*N-1:0]   err;
  logic             stat_clr;
  logic [ACC_W-1:0] txn_cnt;
  logic [ACC_W-1:0] err_acc;

  int checks = 0;
  int errors = 0;

  approx_mul_pipe #(.N(N), .L(4), .K(8), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .approx    (approx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .err       (err),
    .stat_clr  (stat_clr),
    .txn_cnt   (txn_cnt),
    .err_acc   (err_acc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one operand pair with out_ready=1 and returns the first result seen.
  // lat counts rising edges from the accept edge (inclusive) until out_valid
  // is seen; -1 means the result never arrived within the bound.
  task automatic run_one(input logic [7:0] xa, input logic [7:0] ya, input logic aa,
                         output logic [15:0] zo, output logic [15:0] eo,
                         output int lat);
    in_valid  = 1'b1;
    x         = xa;
    y         = ya;
    approx    = aa;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = -1;
    zo  = '0;
    eo  = '0;
    for (int c = 1; c <= 10; c++) begin
      if (out_valid) begin
        lat = c;
        zo  = z;
        eo  = err;
        break;
      end
      tick();
    end
    tick();  // result consumed at this edge
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || z !== 16'd0 || err !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b in_ready=%b z=%0d err=%0d, required 0 1 0 0",
               out_valid, in_ready, z, err);
    end
    checks++;
    if (txn_cnt !== 16'd0 || err_acc !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: txn_cnt=%0d err_acc=%0d, required 0 0", txn_cnt, err_acc);
    end
  endtask

  task automatic test_basic();
    logic [15:0] zo, eo;
    int lat;
    logic [7:0]  tx [4] = '{8'd255, 8'd255, 8'd16,  8'd15};
    logic [7:0]  ty [4] = '{8'd255, 8'd255, 8'd200, 8'd255};
    logic        ta [4] = '{1'b1,   1'b0,   1'b1,   1'b1};
    logic [15:0] ez [4] = '{16'd64016, 16'd65025, 16'd3200, 16'd2816};
    logic [15:0] ee [4] = '{16'd1009,  16'd0,     16'd0,    16'd1009};
    for (int k = 0; k < 4; k++) begin
      run_one(tx[k], ty[k], ta[k], zo, eo, lat);
      checks++;
      if (zo !== ez[k] || eo !== ee[k]) begin
        errors++;
        $display("FAIL basic_%0d: z=%0d err=%0d, required z=%0d err=%0d", k, zo, eo, ez[k], ee[k]);
      end
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL latency_%0d: out_valid after %0d edges, required 2", k, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  tx [8] = '{8'd255, 8'd15,  8'd16,  8'd3,   8'd200, 8'd9,   8'd255, 8'd1};
    logic [7:0]  ty [8] = '{8'd255, 8'd255, 8'd200, 8'd100, 8'd3,   8'd129, 8'd255, 8'd1};
    logic        ta [8] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
    logic [15:0] ez [8] = '{16'd64016, 16'd2816, 16'd3200, 16'd0,
                            16'd600,   16'd1024, 16'd65025, 16'd0};
    logic [15:0] ee [8] = '{16'd1009, 16'd1009, 16'd0, 16'd300,
                            16'd0,    16'd137,  16'd0, 16'd1};
    int wr = 0;
    int rd = 0;
    int cyc = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_z = '0;
    logic [15:0] prev_e = '0;
    int hold_bad = 0;
    int rdy_bad  = 0;
    while (rd < 8 && cyc < 200) begin
      if (prev_stall && (out_valid !== 1'b1 || z !== prev_z || err !== prev_e)) hold_bad++;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (wr < 8);
      x         = tx[wr % 8];
      y         = ty[wr % 8];
      approx    = ta[wr % 8];
      #1;
      // Two accepted-but-undelivered results means both stages are full.
      if (in_ready !== !((wr - rd) == 2 && !out_ready)) rdy_bad++;
      if (out_valid && out_ready) begin
        checks++;
        if (z !== ez[rd] || err !== ee[rd]) begin
          errors++;
          $display("FAIL stream_%0d: z=%0d err=%0d, required z=%0d err=%0d",
                   rd, z, err, ez[rd], ee[rd]);
        end
        rd++;
      end
      if (in_valid && in_ready) wr++;
      prev_stall = out_valid && !out_ready;
      prev_z     = z;
      prev_e     = err;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (rd != 8) begin
      errors++;
      $display("FAIL stream_count: delivered %0d, required 8", rd);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL stream_hold: %0d stalled cycles changed, required 0", hold_bad);
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("FAIL stream_in_ready: %0d cycles wrong, required 0", rdy_bad);
    end
    out_ready = 1'b1;
    hold_bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) hold_bad++;
      tick();
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL stream_extra: %0d extra results, required 0", hold_bad);
    end
  endtask

  task automatic test_stats();
    logic [15:0] zo, eo;
    int lat;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++;
    if (txn_cnt !== 16'd0 || err_acc !== 16'd0) begin
      errors++;
      $display("FAIL stat_clear: txn_cnt=%0d err_acc=%0d, required 0 0", txn_cnt, err_acc);
    end
    for (int k = 0; k < 3; k++) run_one(8'd255, 8'd255, 1'b1, zo, eo, lat);
    checks++;
    if (txn_cnt !== 16'd3 || err_acc !== 16'd3027) begin
      errors++;
      $display("FAIL stat_three: txn_cnt=%0d err_acc=%0d, required 3 3027", txn_cnt, err_acc);
    end
    // Fourth transaction with stat_clr in its handshake cycle.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stat_fourth_valid: out_valid=%b, required 1", out_valid);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++;
    if (txn_cnt !== 16'd1 || err_acc !== 16'd1009) begin
      errors++;
      $display("FAIL stat_clr_hs: txn_cnt=%0d err_acc=%0d, required 1 1009", txn_cnt, err_acc);
    end
  endtask

  task automatic test_saturation();
    stat_clr = 1'b1;
    tick();
    stat_clr  = 1'b0;
    out_ready = 1'b1;
    x = 8'd255;
    y = 8'd255;
    approx = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 65; k++) tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (txn_cnt !== 16'd65 || err_acc !== 16'd65535) begin
      errors++;
      $display("FAIL saturation: txn_cnt=%0d err_acc=%0d, required 65 65535", txn_cnt, err_acc);
    end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] zo, eo;
    int lat;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x = 8'd255; y = 8'd255; approx = 1'b1;
    tick();
    x = 8'd15;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || txn_cnt !== 16'd0 || err_acc !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midflight: out_valid=%b txn_cnt=%0d err_acc=%0d in_ready=%b, required 0 0 0 1",
               out_valid, txn_cnt, err_acc, in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    run_one(8'd3, 8'd100, 1'b1, zo, eo, lat);
    checks++;
    if (zo !== 16'd0 || eo !== 16'd300 || lat != 2) begin
      errors++;
      $display("FAIL post_reset: z=%0d err=%0d lat=%0d, required z=0 err=300 lat=2", zo, eo, lat);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    approx    = 1'b0;
    out_ready = 1'b0;
    stat_clr  = 1'b0;
    #12;
    test_reset();
    tick();
    rst = 1'b0;
    tick();
    test_basic();
    test_back_to_back();
    test_stats();
    test_saturation();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
